uart_rx: RTL

UART receiver that consumes the serial line driven by the team's UART transmitter: 8N1 frames, LSB first, idle-high, at the same baud divisor.
- Synchronizes the asynchronous line and validates the start bit at mid-bit.
- Samples each data bit and the stop bit at mid-bit.
- Presents each received byte on a valid/ready handshake with frame and overrun error flags.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync.sv | 33 +++
 rtl/uart_rx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: frame format, default baud divisor and rx state encoding.
package uart_pkg;

    localparam int UART_WL       = 8;
    localparam int UART_BAUD_DIV = 10418;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_BREAK  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = RX_IDLE,
        ST_START  = RX_START,
        ST_DATA   = RX_DATA,
        ST_PARITY = RX_PARITY,
        ST_STOP   = RX_STOP,
        ST_BREAK  = RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Single-bit multi-flop synchronizer for asynchronous inputs; flops reset to 1 (idle line).
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic [STAGES:0] chain;

    assign chain[0] = d;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic ff_reg;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    ff_reg <= 1'b1;
                end else begin
                    ff_reg <= chain[gi];
                end
            end

            assign chain[gi+1] = ff_reg;
        end
    endgenerate

    assign q = chain[STAGES];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, LSB first, idle-high, mid-bit sampling, valid/ready output with error flags.
// Define UART_RX_PARITY_EN to receive one even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int WL          = UART_WL,
    parameter int BAUD_DIV    = UART_BAUD_DIV,
    parameter int SYNC_STAGES = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          sig_in,
    output logic [WL-1:0] data,
    output logic          valid,
    input  logic          ready,
    output logic          frame_err,
    output logic          overrun,
    output logic          parity_err,
    output logic          busy
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(WL);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WL - 1);

    logic            rx_s;
    rx_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [WL-1:0]   shift_reg;
    logic [WL-1:0]   data_reg;
    logic            valid_reg;
    logic            frame_err_reg;
    logic            overrun_reg;
    logic            frame_done;
    logic            accept;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK  (CLK),
        .RST_N(RST_N),
        .d    (sig_in),
        .q    (rx_s)
    );

    assign frame_done = (state_reg == ST_STOP) && (cnt_reg == CNT_FULL);
    assign accept     = valid_reg & ready;

`ifdef UART_RX_PARITY_EN
    logic par_bit_reg;
    logic parity_err_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            par_bit_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            if (state_reg == ST_PARITY && cnt_reg == CNT_FULL) begin
                par_bit_reg <= rx_s;
            end
            // Even parity: the data bits plus the parity bit must XOR to zero.
            if (frame_done) begin
                parity_err_reg <= (^shift_reg) ^ par_bit_reg;
            end
        end
    end

    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            // A completing frame takes priority over a same-cycle accept: the new byte wins.
            if (frame_done) begin
                data_reg      <= shift_reg;
                frame_err_reg <= ~rx_s;
                valid_reg     <= 1'b1;
                overrun_reg   <= valid_reg & ~ready;
            end else if (accept) begin
                valid_reg   <= 1'b0;
                overrun_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    if (!rx_s) begin
                        state_reg <= ST_START;
                    end
                end

                ST_START: begin
                    if (cnt_reg == CNT_HALF) begin
                        cnt_reg   <= '0;
                        idx_reg   <= '0;
                        state_reg <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt_reg == CNT_FULL) begin
                        cnt_reg            <= '0;
                        shift_reg[idx_reg] <= rx_s;
                        if (idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= ST_PARITY;
`else
                            state_reg <= ST_STOP;
`endif
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_reg == CNT_FULL) begin
                        cnt_reg   <= '0;
                        state_reg <= ST_STOP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (cnt_reg == CNT_FULL) begin
                        cnt_reg   <= '0;
                        state_reg <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                // Line stuck low after a frame: wait for it to return idle before hunting again.
                ST_BREAK: begin
                    cnt_reg <= '0;
                    if (rx_s) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule
